game_input_ctrl: RTL

//  Front end for the game state machine: conditions three raw active-low board pushbuttons.

---
 rtl/game_input_ctrl_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 52 +++++
 rtl/game_input_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/game_input_ctrl_pkg.sv
// Shared game FSM state codes and the state-gating helpers used by the
// pushbutton front end.
package game_input_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_START    = 3'b000,
        ST_PLAYING  = 3'b001,
        ST_PAUSE    = 3'b010,
        ST_RESET    = 3'b011,
        ST_GAMEOVER = 3'b100
    } game_state_e;

    // Codes 101..111 match neither helper, so they suppress every request.
    function automatic logic start_allowed(input logic [2:0] st);
        return (st == ST_START) || (st == ST_RESET) || (st == ST_GAMEOVER);
    endfunction

    function automatic logic in_play(input logic [2:0] st);
        return (st == ST_PLAYING) || (st == ST_PAUSE);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-FF synchroniser, counter debounce, accepted level and a
// one-cycle strobe on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_q;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_q <= 1'b0;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= ~btn_n;
            r_sync2    <= r_sync1;
            r_stable_q <= r_stable;
            r_press    <= r_stable & ~r_stable_q;
            // Any return to the accepted level restarts the qualification window.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Level is taken from the delayed copy so it moves in step with press.
    assign level = r_stable_q;
    assign press = r_press;

endmodule

// File: rtl/game_input_ctrl.sv
// Pushbutton front end for the game FSM: three debounced buttons turned into
// state-gated start/reset pulses and a pause level.
module game_input_ctrl
    import game_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btnStart_n,
    input  logic       btnPause_n,
    input  logic       btnReset_n,
    input  logic [2:0] gameState,
    output logic       startGame,
    output logic       pauseGame,
    output logic       resetGame,
    output logic [2:0] btnLevel
);

    logic       w_start_ev;
    logic       w_pause_ev;
    logic       w_reset_ev;
    logic [2:0] w_level;
    logic       w_start_next;
    logic       w_reset_next;
    logic       w_pause_next;

    logic       r_start;
    logic       r_pause;
    logic       r_reset;
    logic [2:0] r_level;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_start (
        .clk(clk), .reset_n(reset_n), .btn_n(btnStart_n),
        .level(w_level[0]), .press(w_start_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_pause (
        .clk(clk), .reset_n(reset_n), .btn_n(btnPause_n),
        .level(w_level[1]), .press(w_pause_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_reset (
        .clk(clk), .reset_n(reset_n), .btn_n(btnReset_n),
        .level(w_level[2]), .press(w_reset_ev)
    );

    always_comb begin
        w_start_next = w_start_ev & start_allowed(gameState);
        w_reset_next = w_reset_ev & in_play(gameState);
        w_pause_next = r_pause;
        // A reset request beats a simultaneous pause toggle so the FSM sees pause low.
        if (!in_play(gameState)) begin
            w_pause_next = 1'b0;
        end else if (w_reset_ev) begin
            w_pause_next = 1'b0;
        end else if (w_pause_ev) begin
            w_pause_next = ~r_pause;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start <= 1'b0;
            r_pause <= 1'b0;
            r_reset <= 1'b0;
            r_level <= 3'b000;
        end else begin
            r_start <= w_start_next;
            r_pause <= w_pause_next;
            r_reset <= w_reset_next;
            r_level <= w_level;
        end
    end

    assign startGame = r_start;
    assign pauseGame = r_pause;
    assign resetGame = r_reset;
    assign btnLevel  = r_level;

endmodule
